aes_round_ctrl: RTL and testbench

Iterative sequencer for the AES-128 round datapath. It accepts one block job (state and `job_t` type) over a valid/ready handshake. It performs the initial AddRoundKey itself, then issues the NR rounds one at a time to the external round unit, with the final round flagged. It returns the result over a second valid/ready handshake. It sits between the accelerator front-end and the shared round unit/round-key store, and owns round-key index ordering for both encrypt and decrypt.

---
 rtl/aes_round_ctrl.sv | 154 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: iterative AES-128 sequencer; does the initial AddRoundKey, then issues NR rounds to an external round unit.
// Optional build macro AES_CTRL_ZEROIZE_EN: scrub state after hand-off and gate idle datapath outputs to zero.

typedef enum logic [1:0] {
  INVALID = 2'd0,
  ENCRYPT = 2'd1,
  DECRYPT = 2'd2
} job_t;

module aes_round_ctrl #(
  parameter int NR      = 10,
  parameter int RND_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  job_t         in_type,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output job_t         out_type,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic         rnd_issue,
  output logic [127:0] rnd_state,
  output logic [127:0] rnd_key,
  output job_t         rnd_type,
  output logic         rnd_last,
  input  logic [127:0] rnd_result,
  input  logic         abort,
  output logic         busy,
  output logic         err_drop,
  output logic [15:0]  job_cnt
);

  localparam int LW = 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          r_state;
  logic [127:0]    r_st;
  job_t            r_typ;
  logic [3:0]      r_rnd;
  logic [LW-1:0]   r_lat_cnt;
  logic [15:0]     r_job_cnt;
  logic            r_err_drop;

  logic            w_in_rnd;
  logic            w_job_ok;
  logic [3:0]      w_rnd_idx;
  logic [3:0]      w_rk_idx;

  assign w_in_rnd  = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign w_job_ok  = (in_type == ENCRYPT) || (in_type == DECRYPT);
  // Decrypt walks the key schedule backwards: round r uses key NR-r.
  assign w_rnd_idx = (r_typ == ENCRYPT) ? r_rnd : (4'(NR) - r_rnd);

  always_comb begin
    w_rk_idx = 4'd0;
    case (r_state)
      S_IDLE:          w_rk_idx = (in_type == DECRYPT) ? 4'(NR) : 4'd0;
      S_ISSUE, S_WAIT: w_rk_idx = w_rnd_idx;
      default:         w_rk_idx = 4'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_st       <= '0;
      r_typ      <= INVALID;
      r_rnd      <= '0;
      r_lat_cnt  <= '0;
      r_job_cnt  <= '0;
      r_err_drop <= 1'b0;
    end else begin
      r_err_drop <= 1'b0;
      if (abort) begin
        // Any result still in the round unit is simply never sampled.
        r_state   <= S_IDLE;
        r_st      <= '0;
        r_typ     <= INVALID;
        r_rnd     <= '0;
        r_lat_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (in_valid) begin
              if (w_job_ok) begin
                r_st    <= in_state ^ rk_data;
                r_typ   <= in_type;
                r_rnd   <= 4'd1;
                r_state <= S_ISSUE;
              end else begin
                r_err_drop <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            r_lat_cnt <= LW'(RND_LAT - 1);
            r_state   <= S_WAIT;
          end
          S_WAIT: begin
            if (r_lat_cnt == '0) begin
              r_st <= rnd_result;
              if (r_rnd == 4'(NR)) begin
                r_state <= S_DONE;
              end else begin
                r_rnd   <= r_rnd + 4'd1;
                r_state <= S_ISSUE;
              end
            end else begin
              r_lat_cnt <= r_lat_cnt - LW'(1);
            end
          end
          S_DONE: begin
            if (out_ready) begin
              r_job_cnt <= r_job_cnt + 16'd1;
              r_state   <= S_IDLE;
`ifdef AES_CTRL_ZEROIZE_EN
              r_st      <= '0;
              r_typ     <= INVALID;
`endif
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !abort;
  assign out_valid = (r_state == S_DONE);
  assign out_type  = r_typ;
  assign busy      = (r_state != S_IDLE);
  assign rk_idx    = w_rk_idx;
  assign rnd_issue = (r_state == S_ISSUE);
  assign rnd_key   = rk_data;
  assign rnd_type  = w_in_rnd ? r_typ : INVALID;
  assign rnd_last  = w_in_rnd && (r_rnd == 4'(NR));
  assign err_drop  = r_err_drop;
  assign job_cnt   = r_job_cnt;

`ifdef AES_CTRL_ZEROIZE_EN
  assign out_data  = (r_state == S_DONE) ? r_st : '0;
  assign rnd_state = w_in_rnd ? r_st : '0;
`else
  assign out_data  = r_st;
  assign rnd_state = r_st;
`endif

endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: FIPS-197 vectors through two controllers (RND_LAT=1 and 3) with a behavioural
// round unit and key store; AES_CTRL_ZEROIZE_EN selects the post-handshake out_data expectation.
module tb_aes_round_ctrl;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] POISON = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
`ifdef AES_CTRL_ZEROIZE_EN
  localparam logic ZEROIZE = 1'b1;
`else
  localparam logic ZEROIZE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk    [11];
  int n_chk = 0;
  int n_fail = 0;

  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_rnd_issue, a_rnd_last;
  logic         a_abort, a_busy, a_err_drop;
  logic [127:0] a_in_state, a_out_data, a_rk_data, a_rnd_state, a_rnd_key, a_rnd_result;
  job_t         a_in_type, a_out_type, a_rnd_type;
  logic [3:0]   a_rk_idx;
  logic [15:0]  a_job_cnt;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_rnd_issue, b_rnd_last;
  logic         b_abort, b_busy, b_err_drop;
  logic [127:0] b_in_state, b_out_data, b_rk_data, b_rnd_state, b_rnd_key, b_rnd_result;
  job_t         b_in_type, b_out_type, b_rnd_type;
  logic [3:0]   b_rk_idx;
  logic [15:0]  b_job_cnt;

  aes_round_ctrl #(.NR(10), .RND_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_state(a_in_state), .in_type(a_in_type), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_type(a_out_type), .rk_idx(a_rk_idx), .rk_data(a_rk_data),
    .rnd_issue(a_rnd_issue), .rnd_state(a_rnd_state), .rnd_key(a_rnd_key), .rnd_type(a_rnd_type),
    .rnd_last(a_rnd_last), .rnd_result(a_rnd_result), .abort(a_abort), .busy(a_busy),
    .err_drop(a_err_drop), .job_cnt(a_job_cnt));

  aes_round_ctrl #(.NR(10), .RND_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_state(b_in_state), .in_type(b_in_type), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_type(b_out_type), .rk_idx(b_rk_idx), .rk_data(b_rk_data),
    .rnd_issue(b_rnd_issue), .rnd_state(b_rnd_state), .rnd_key(b_rnd_key), .rnd_type(b_rnd_type),
    .rnd_last(b_rnd_last), .rnd_result(b_rnd_result), .abort(b_abort), .busy(b_busy),
    .err_drop(b_err_drop), .job_cnt(b_job_cnt));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] mixcols(input logic [127:0] s, input logic inv);
    logic [7:0] m [4];
    logic [7:0] v;
    logic [127:0] r;
    if (inv) begin m[0] = 8'h0e; m[1] = 8'h0b; m[2] = 8'h0d; m[3] = 8'h09; end
    else     begin m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01; end
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        v = '0;
        for (int j = 0; j < 4; j++) v ^= gmul(m[(j - i + 4) % 4], s[127 - 8*(4*c + j) -: 8]);
        r[127 - 8*(4*c + i) -: 8] = v;
      end
    return r;
  endfunction

  // One AES round as the external round unit performs it (inverse-cipher order for decrypt).
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input job_t t, input logic last);
    logic [127:0] r;
    logic [7:0] x;
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        if (t == DECRYPT) begin
          x = s[127 - 8*(i + 4*((c - i + 4) % 4)) -: 8];
          r[127 - 8*(i + 4*c) -: 8] = isbox[x];
        end else begin
          x = s[127 - 8*(i + 4*((c + i) % 4)) -: 8];
          r[127 - 8*(i + 4*c) -: 8] = sbox[x];
        end
      end
    if (t == DECRYPT) begin
      r ^= k;
      if (!last) r = mixcols(r, 1'b1);
    end else begin
      if (!last) r = mixcols(r, 1'b0);
      r ^= k;
    end
    return r;
  endfunction

  task automatic build_tables();
    logic [7:0] inv, s, rc;
    logic [31:0] w [44];
    logic [31:0] t;
    logic [127:0] kv;
    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
    kv = KEY;
    for (int i = 0; i < 4; i++) w[i] = kv[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Key store: combinational lookup on the requested index.
  assign a_rk_data = (a_rk_idx <= 4'd10) ? rk[a_rk_idx] : '0;
  assign b_rk_data = (b_rk_idx <= 4'd10) ? rk[b_rk_idx] : '0;

  // Round units: result becomes visible exactly RND_LAT edges after the issue edge, poison otherwise.
  logic [127:0] a_pipe [4];
  logic [127:0] b_pipe [4];
  always @(posedge clk) begin
    a_pipe[0] <= a_rnd_issue ? aes_round(a_rnd_state, a_rnd_key, a_rnd_type, a_rnd_last) : POISON;
    b_pipe[0] <= b_rnd_issue ? aes_round(b_rnd_state, b_rnd_key, b_rnd_type, b_rnd_last) : POISON;
    for (int i = 1; i < 4; i++) begin
      a_pipe[i] <= a_pipe[i-1];
      b_pipe[i] <= b_pipe[i-1];
    end
  end
  assign a_rnd_result = a_pipe[0];
  assign b_rnd_result = b_pipe[2];

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // Runs one job on dut_a from a negedge; ends on the negedge after the output handshake.
  task automatic run_a(input job_t t, input logic [127:0] din, input logic [127:0] dexp,
                       input logic [43:0] seq_exp, input int stall);
    logic [43:0] seq;
    logic [9:0] lst;
    logic [15:0] cnt0, cexp;
    logic got, stable;
    int iss, n;
    a_in_valid = 1'b1; a_in_type = t; a_in_state = din;
    #1;
    chk("in_ready_idle", a_in_ready, 1);
    seq  = 44'(a_rk_idx);
    cnt0 = a_job_cnt;
    @(posedge clk);
    n = 0; got = 1'b0; iss = 0; lst = '0;
    while (!got && n < 200) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      n++;
      if (a_rnd_issue) begin
        seq = {seq[39:0], a_rk_idx};
        lst = {lst[8:0], a_rnd_last};
        iss++;
      end
      if (a_out_valid) got = 1'b1;
    end
    chk("latency", n, 21);
    chk("issues", iss, 10);
    chk("rk_idx_seq", seq, seq_exp);
    chk("rnd_last_seq", lst, 10'b0000000001);
    chk("out_data", a_out_data, dexp);
    chk("out_type", a_out_type, t);
    stable = 1'b1;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      if (!a_out_valid || a_out_data !== dexp || a_in_ready || a_job_cnt !== cnt0) stable = 1'b0;
    end
    if (stall > 0) chk("stall_hold", stable, 1);
    a_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_out_ready = 1'b0;
    cexp = cnt0 + 16'd1;
    chk("job_cnt_inc", a_job_cnt, cexp);
    chk("out_valid_drop", a_out_valid, 0);
    chk("out_data_after", a_out_data, ZEROIZE ? 128'h0 : dexp);
    chk("in_ready_after", a_in_ready, 1);
  endtask

  initial begin
    int n, iss, drops;
    logic got, bz, any_iss, seen;
    a_in_valid = 0; a_out_ready = 0; a_abort = 0; a_in_state = '0; a_in_type = ENCRYPT;
    b_in_valid = 0; b_out_ready = 0; b_abort = 0; b_in_state = '0; b_in_type = ENCRYPT;
    build_tables();
    chk("rk10", rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    repeat (2) @(negedge clk);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_type", a_out_type, INVALID);
    chk("rst_busy", a_busy, 0);
    chk("rst_rnd_issue", a_rnd_issue, 0);
    chk("rst_err_drop", a_err_drop, 0);
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_job_cnt", a_job_cnt, 0);
    chk("rst_rk_idx_enc", a_rk_idx, 0);
    chk("rst_rnd_type", a_rnd_type, INVALID);
    a_in_type = DECRYPT; a_abort = 1'b1;
    #1;
    chk("rst_rk_idx_dec", a_rk_idx, 10);
    chk("abort_blocks_ready", a_in_ready, 0);
    a_abort = 1'b0; a_in_type = ENCRYPT;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_a(ENCRYPT, PT, CT, 44'h0123456789A, 5);
    run_a(DECRYPT, CT, PT, 44'hA9876543210, 0);

    // INVALID job is dropped without starting anything
    a_in_valid = 1'b1; a_in_type = INVALID; a_in_state = PT;
    drops = 0; bz = 1'b0; any_iss = 1'b0;
    #1;
    drops += int'(a_err_drop);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      drops += int'(a_err_drop);
      bz |= a_busy;
      any_iss |= a_rnd_issue;
    end
    chk("err_drop_pulses", drops, 1);
    chk("invalid_busy", bz, 0);
    chk("invalid_issue", any_iss, 0);
    chk("invalid_job_cnt", a_job_cnt, 2);

    // abort while in IDLE with a pending request: nothing accepted
    a_abort = 1'b1; a_in_valid = 1'b1; a_in_type = ENCRYPT; a_in_state = PT;
    #1;
    chk("abort_idle_ready", a_in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    a_abort = 1'b0; a_in_valid = 1'b0;
    chk("abort_idle_busy", a_busy, 0);

    // abort during WAIT of round 4
    a_in_valid = 1'b1; a_in_type = ENCRYPT; a_in_state = PT;
    @(posedge clk);
    iss = 0; n = 0;
    while (iss < 4 && n < 100) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      n++;
      if (a_rnd_issue) iss++;
    end
    @(negedge clk);
    chk("abort_pre_wait", {a_busy, a_rnd_issue, a_rk_idx}, {1'b1, 1'b0, 4'd4});
    a_abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_abort = 1'b0;
    chk("abort_busy", a_busy, 0);
    chk("abort_out_data", a_out_data, 0);
    chk("abort_out_type", a_out_type, INVALID);
    chk("abort_rnd_last", a_rnd_last, 0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      seen |= a_out_valid;
    end
    chk("abort_no_out_valid", seen, 0);
    chk("abort_job_cnt", a_job_cnt, 2);

    // job counter wrap
    force dut_a.r_job_cnt = 16'hffff;
    #1;
    release dut_a.r_job_cnt;
    chk("job_cnt_preload", a_job_cnt, 16'hffff);
    run_a(ENCRYPT, PT, CT, 44'h0123456789A, 0);
    chk("job_cnt_wrap", a_job_cnt, 0);

    // asynchronous reset mid-job
    a_in_valid = 1'b1; a_in_type = ENCRYPT; a_in_state = PT;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", a_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", a_busy, 0);
    chk("arst_out_data", a_out_data, 0);
    chk("arst_out_type", a_out_type, INVALID);
    chk("arst_rnd_issue", a_rnd_issue, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RND_LAT=3 instance
    b_in_valid = 1'b1; b_in_type = ENCRYPT; b_in_state = PT;
    @(posedge clk);
    n = 0; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      n++;
      if (b_out_valid) got = 1'b1;
    end
    chk("lat3_latency", n, 41);
    chk("lat3_out_data", b_out_data, CT);
    chk("lat3_out_type", b_out_type, ENCRYPT);
    b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("lat3_job_cnt", b_job_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
